// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin arbiter that shares one combinational 32-bit ALU between NREQ
// requesters. Each cycle it grants at most one valid request, drives that request's opcode and
// operands onto the ALU, and captures result, zero flag and requester ID in a one-entry response
// register with a valid/ready handshake.
//
// Optional feature: define ALU_ARB_OPCHECK_EN to trap opcodes 10..15. Such a request is consumed,
// the ALU sees an ADD of zeros, and the response carries result 0, zero 1, err 1.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_ready [NREQ]     per-requester handshake
//   req_op/req_a/req_b             packed request fields, requester i in slice i
//   alu_op/alu_operand_a/_b        drive to the shared ALU (zero when idle)
//   alu_result/alu_zero            combinational ALU outputs
//   rsp_valid/rsp_ready            response handshake
//   rsp_id/rsp_result/rsp_zero/rsp_err  registered response fields
module alu_share_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [4*NREQ-1:0]  req_op,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  output logic [3:0]         alu_op,
  output logic [31:0]        alu_operand_a,
  output logic [31:0]        alu_operand_b,
  input  logic [31:0]        alu_result,
  input  logic               alu_zero,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [31:0]        rsp_result,
  output logic               rsp_zero,
  output logic               rsp_err
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] gnt_idx, idx;
  logic           gnt_any, gnt, can_issue, illegal;
  logic [IDW-1:0] rsp_id_q;
  logic [31:0]    rsp_result_q;
  logic           rsp_zero_q;

  logic [3:0]  op_arr [NREQ];
  logic [31:0] a_arr  [NREQ];
  logic [31:0] b_arr  [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign op_arr[i] = req_op[4*i +: 4];
    assign a_arr[i]  = req_a[32*i +: 32];
    assign b_arr[i]  = req_b[32*i +: 32];
  end

  // Rotating priority search starting at ptr_q. rst_n gates the grant so nothing is
  // consumed while reset is held.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    can_issue = (state_q == StEmpty) | rsp_ready;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IDW'((32'(ptr_q) + k) % NREQ);
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
    gnt = gnt_any & can_issue & rst_n;
    req_ready = '0;
    if (gnt) req_ready[gnt_idx] = 1'b1;
  end

`ifdef ALU_ARB_OPCHECK_EN
  assign illegal = op_arr[gnt_idx] > 4'd9;
`else
  assign illegal = 1'b0;
`endif

  // ALU sees an ADD of zeros whenever nothing legal is granted.
  always_comb begin
    alu_op        = 4'd0;
    alu_operand_a = 32'd0;
    alu_operand_b = 32'd0;
    if (gnt && !illegal) begin
      alu_op        = op_arr[gnt_idx];
      alu_operand_a = a_arr[gnt_idx];
      alu_operand_b = b_arr[gnt_idx];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StEmpty: if (gnt) state_d = StFull;
      StFull:  if (!gnt && rsp_ready) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
    if (gnt) ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StEmpty;
      ptr_q        <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= 32'd0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (gnt) begin
        rsp_id_q     <= gnt_idx;
        rsp_result_q <= illegal ? 32'd0 : alu_result;
        rsp_zero_q   <= illegal ? 1'b1 : alu_zero;
      end
    end
  end

`ifdef ALU_ARB_OPCHECK_EN
  logic rsp_err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err_q <= 1'b0;
    end else if (gnt) begin
      rsp_err_q <= illegal;
    end
  end
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign rsp_valid  = (state_q == StFull);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with NREQ=2: a reference model predicts grants and
// responses from the request fields; a monitor pops and compares each response as it drains.
module tb_alu_share_arbiter;
  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid, req_ready;
  logic [4*NREQ-1:0]  req_op;
  logic [32*NREQ-1:0] req_a, req_b;
  logic [3:0]         alu_op;
  logic [31:0]        alu_operand_a, alu_operand_b, alu_result;
  logic               alu_zero;
  logic               rsp_valid, rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_result;
  logic               rsp_zero, rsp_err;

  alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .alu_op(alu_op),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_result(alu_result), .alu_zero(alu_zero), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return $unsigned($signed(a) >>> b[4:0]);
      4'd8: return {31'd0, $signed(a) < $signed(b)};
      4'd9: return {31'd0, a < b};
      default: return 32'd0;
    endcase
  endfunction

  // Stand-in for the shared ALU instance.
  always_comb begin
    alu_result = alu_fn(alu_op, alu_operand_a, alu_operand_b);
    alu_zero   = (alu_result == 32'd0);
  end

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    res;
    logic           zero;
    logic           err;
  } rsp_t;

  rsp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int m_ptr = 0;
  bit m_full = 1'b0;
  logic [NREQ-1:0] gnt_seen = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: rotating priority from m_ptr, one-entry response slot.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_ptr = 0;
      m_full = 1'b0;
      gnt_seen = '0;
      exp_q.delete();
    end else begin
      int g;
      logic [NREQ-1:0] exp_rdy;
      logic [3:0] op, e_op;
      logic [31:0] a, b, e_a, e_b;
      rsp_t r;
      g = -1;
      exp_rdy = '0;
      e_op = 4'd0; e_a = 32'd0; e_b = 32'd0;
      check("rsp_valid", {63'd0, rsp_valid}, {63'd0, m_full});
      if (!m_full || rsp_ready) begin
        for (int k = 0; k < NREQ; k++) begin
          int i;
          i = (m_ptr + k) % NREQ;
          if (g < 0 && req_valid[i]) g = i;
        end
      end
      if (g >= 0) begin
        exp_rdy[g] = 1'b1;
        op = req_op[4*g +: 4];
        a  = req_a[32*g +: 32];
        b  = req_b[32*g +: 32];
        r.id = IDW'(g);
`ifdef ALU_ARB_OPCHECK_EN
        if (op > 4'd9) begin
          r.res = 32'd0; r.zero = 1'b1; r.err = 1'b1;
        end else begin
          e_op = op; e_a = a; e_b = b;
          r.res = alu_fn(op, a, b); r.zero = (r.res == 32'd0); r.err = 1'b0;
        end
`else
        e_op = op; e_a = a; e_b = b;
        r.res = alu_fn(op, a, b); r.zero = (r.res == 32'd0); r.err = 1'b0;
`endif
        exp_q.push_back(r);
        m_ptr = (g + 1) % NREQ;
      end
      check("req_ready", {62'd0, req_ready}, {62'd0, exp_rdy});
      check("alu_drive", {28'd0, alu_op, alu_operand_a}, {28'd0, e_op, e_a});
      check("alu_operand_b", {32'd0, alu_operand_b}, {32'd0, e_b});
      m_full = (g >= 0) || (m_full && !rsp_ready);
      gnt_seen = exp_rdy;
    end
  end

  // Monitor: each response is compared on the cycle it is accepted.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got id %0d result 0x%0h expected none", rsp_id, rsp_result);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_id", {63'd0, rsp_id}, {63'd0, e.id});
        check("rsp_result", {32'd0, rsp_result}, {32'd0, e.res});
        check("rsp_zero", {63'd0, rsp_zero}, {63'd0, e.zero});
        check("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    req_op[4*i +: 4]   = op;
    req_a[32*i +: 32]  = a;
    req_b[32*i +: 32]  = b;
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 3))
      0: return 32'd0;
      1: return 32'hffff_ffff;
      2: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #1;
    check("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("reset_rsp_fields", {30'd0, rsp_id, rsp_result, rsp_zero, rsp_err}, 64'd0);
    tick(); tick();
    rst_n = 1'b1;

    // Single request: 5 + 3.
    set_req(0, 4'd0, 32'd5, 32'd3);
    req_valid = 2'b01; rsp_ready = 1'b1;
    tick();
    req_valid = 2'b00;
    check("single_valid", {63'd0, rsp_valid}, 64'd1);
    check("single_result", {32'd0, rsp_result}, 64'd8);
    tick();

    // Round robin with both requesters continuously valid.
    set_req(0, 4'd1, 32'h401e_1042, 32'h7fff_ffff);
    set_req(1, 4'd4, 32'hffff_ffff, 32'hffff_ffff);
    req_valid = 2'b11;
    repeat (4) tick();

    // Backpressure with SLTU pending on requester 1.
    req_valid = 2'b00; rsp_ready = 1'b0;
    set_req(1, 4'd9, 32'd1, 32'hffff_ffff);
    req_valid = 2'b10;
    repeat (3) begin
      tick();
      check("bp_ready", {62'd0, req_ready}, 64'd0);
    end
    rsp_ready = 1'b1;
    tick();
    req_valid = 2'b00;
    check("bp_result", {32'd0, rsp_result}, 64'd1);
    check("bp_id", {63'd0, rsp_id}, 64'd1);
    tick();

    // Illegal opcode.
    set_req(0, 4'd12, 32'h1234_5678, 32'h9abc_def0);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();

    // Idle.
    repeat (5) tick();
    check("idle_valid", {63'd0, rsp_valid}, 64'd0);

    // Reset mid-operation while a response is held.
    set_req(0, 4'd0, 32'd7, 32'd9);
    set_req(1, 4'd3, 32'hf0, 32'h0f);
    req_valid = 2'b11; rsp_ready = 1'b0;
    tick(); tick();
    check("pre_reset_valid", {63'd0, rsp_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_valid", {63'd0, rsp_valid}, 64'd0);
    check("mid_reset_ready", {62'd0, req_ready}, 64'd0);
    check("mid_reset_alu", {28'd0, alu_op, alu_operand_a}, 64'd0);
    check("mid_reset_fields", {30'd0, rsp_id, rsp_result, rsp_zero, rsp_err}, 64'd0);
    tick();
    rst_n = 1'b1; rsp_ready = 1'b1;
    #3;
    check("post_reset_grant", {62'd0, req_ready}, 64'd1);
    tick();
    req_valid = 2'b00;
    tick();

    // Random traffic honouring the hold-until-granted rule.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rsp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || gnt_seen[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          set_req(i, ($urandom_range(0, 7) == 0) ? 4'(10 + $urandom_range(0, 5))
                                                 : 4'($urandom_range(0, 9)), rnd32(), rnd32());
        end
      end
      tick();
    end

    req_valid = '0; rsp_ready = 1'b1;
    repeat (4) tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter and sequencer that shares the single combinational 32-bit ALU between NREQ requesters (e.g. the execute stage, branch-compare and address-generation paths). Each cycle it grants at most one valid request, drives that request's opcode and operands onto the ALU, and captures the result, zero flag and requester ID in a one-entry output register with a valid/ready handshake. It sits between the requesters and the ALU instance and is the only driver of the ALU inputs.

## Interface
- NREQ, 2, number of requesters (2..8)
- IDW, $clog2(NREQ), width of the requester ID
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester grant; transfer when valid & ready
- req_op  in  4*NREQ  packed opcodes, requester i at [4i+3:4i]
- req_a  in  32*NREQ  packed operand A, requester i at [32i+31:32i]
- req_b  in  32*NREQ  packed operand B, same packing
- alu_op  out  4  opcode to the ALU
- alu_operand_a  out  32  operand A to the ALU
- alu_operand_b  out  32  operand B to the ALU
- alu_result  in  32  ALU result (combinational from the outputs above)
- alu_zero  in  1  ALU zero flag
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  IDW  index of the requester that issued the result
- rsp_result  out  32  registered result
- rsp_zero  out  1  registered zero flag
- rsp_err  out  1  illegal opcode flag (see Configuration)

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU; 10..15 illegal.
- can_issue = !rsp_valid | rsp_ready.
- Grant: when can_issue, the first requester i with req_valid[i], searching from pointer ptr upward modulo NREQ, gets req_ready[i]=1; all other req_ready bits are 0. When !can_issue, req_ready = 0.
- Pointer: after a grant to i, ptr <= (i+1) mod NREQ; unchanged with no grant.
- ALU drive: on a grant, alu_op/alu_operand_a/alu_operand_b = granted request's fields; with no grant, they are 0/0/0 (ADD of zeros, deterministic).
- Capture: on a grant, rsp_result <= alu_result, rsp_zero <= alu_zero, rsp_id <= i, rsp_valid <= 1.
- Drain: rsp_valid & rsp_ready with no new grant -> rsp_valid <= 0; rsp_result/rsp_id/rsp_zero hold their last values.
- Simultaneous drain and grant: old response leaves and new one loads in the same edge; rsp_valid stays 1.
- Requesters must hold req_* stable while valid and not granted; the arbiter does not buffer requests.
- Two-state control: EMPTY (rsp_valid=0) and FULL (rsp_valid=1). EMPTY->FULL on grant; FULL->EMPTY on drain without grant; FULL->FULL on drain with grant or on stall.

## Timing
- Reset (async, rst_n low): rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0, ptr=0; req_ready=0 and ALU drive 0 while rst_n is low. Any held response is discarded.
- Latency: request granted in cycle N -> rsp_valid=1 with the result from cycle N+1.
- Throughput: one operation per cycle while rsp_ready stays high.
- req_ready depends combinationally on req_valid, ptr, rsp_valid and rsp_ready; no combinational path from alu_result to req_ready.
- Backpressure: rsp_valid=1 & rsp_ready=0 -> no grants; response is held unchanged.

## Configuration
- ALU_ARB_OPCHECK_EN defined: a granted request with opcode 10..15 is consumed (req_ready=1), the ALU is driven with ADD of zeros, and the response loads rsp_result=0, rsp_zero=1, rsp_err=1; legal opcodes load rsp_err=0.
- Not defined: opcodes are forwarded unchecked; rsp_result/rsp_zero are whatever the ALU returns; rsp_err is tied to 0.

## Test plan
- Single request: req0 ADD 0x00000005+0x00000003, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_result=0x00000008, rsp_zero=0.
- Round-robin: both requesters valid continuously with SUB 0x401e1042-0x7fffffff (req0) and XOR 0xffffffff^0xffffffff (req1), rsp_ready=1 -> grants alternate 0,1,0,1; rsp_result alternates 0xc01e1043 and 0x00000000 with rsp_zero=1 on the latter.
- Backpressure: rsp_ready=0 for 3 cycles with req1 SLTU 1<0xffffffff pending -> req_ready=0 throughout, response held; rsp_ready=1 -> drain and grant same edge, next rsp_result=0x00000001, rsp_id=1.
- Reset mid-operation: assert rst_n=0 while rsp_valid=1 -> rsp_valid=0, ptr=0 immediately; after release with both valid, first grant goes to requester 0.
- Illegal opcode: req0 op=12 -> with ALU_ARB_OPCHECK_EN rsp_err=1, rsp_result=0, rsp_zero=1; without it rsp_err=0.
- Idle: no req_valid for 5 cycles -> alu_op=0, operands 0, rsp_valid stays 0, ptr unchanged.
